uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 157 +++++++++++++++
 tb/tb_uart_rx.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampled UART receiver with mid-bit sampling, parity and framing checks
// rx is double-flopped; the FSM and counters advance only on baud_tick.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE) + 1;
  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic          PAR_EN    = (PARITY != 0);
  localparam logic          PAR_ODD   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t                state;
  logic                  rx_meta;
  logic                  rx_s;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= S_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_flag   <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      data_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (baud_tick && !rx_s) begin
            state    <= S_START;
            tick_cnt <= '0;
            par_flag <= 1'b0;
            rx_busy  <= 1'b1;
          end
        end

        // A start bit that is high again at its midpoint is a glitch, not a frame.
        S_START: begin
          if (baud_tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state   <= S_DATA;
                bit_cnt <= '0;
              end else begin
                state   <= S_IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        S_DATA: begin
          if (baud_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt  <= '0;
              shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
              if (bit_cnt == DATA_LAST) begin
                state <= PAR_EN ? S_PARITY : S_STOP;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        S_PARITY: begin
          if (baud_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              par_flag <= (^shift_reg) ^ rx_s ^ PAR_ODD;
              state    <= S_STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        // A low stop bit may be the start of a break, so wait for the line to recover.
        S_STOP: begin
          if (baud_tick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt   <= '0;
              data_out   <= shift_reg;
              parity_err <= PAR_EN & par_flag;
              frame_err  <= ~rx_s;
              data_valid <= 1'b1;
              if (rx_s) begin
                state   <= S_IDLE;
                rx_busy <= 1'b0;
              end else begin
                state <= S_WAIT_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        S_WAIT_IDLE: begin
          if (baud_tick && rx_s) begin
            state   <= S_IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state    <= S_IDLE;
          tick_cnt <= '0;
          bit_cnt  <= '0;
          rx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx, 8N1 and 8E1 instances side by side
// Expected frames are queued as stimulus is sent; the monitor queues what the DUTs report.
module tb_uart_rx;

  localparam int OS = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          baud_tick;
  logic          rx0, rx1;
  logic [DW-1:0] dout0, dout1;
  logic          dv0, dv1, perr0, perr1, ferr0, ferr1, busy0, busy1;

  logic [9:0] exp0[$], exp1[$], obs0[$], obs1[$];
  int errors = 0;
  int checks = 0;
  int vcount0 = 0;
  int vcount1 = 0;
  int tick_mode = 0;

  always #5 clk = ~clk;

  uart_rx #(.DATA_WIDTH(DW), .PARITY(0), .OVERSAMPLE(OS)) dut0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx0),
    .data_out(dout0), .data_valid(dv0), .parity_err(perr0),
    .frame_err(ferr0), .rx_busy(busy0)
  );

  uart_rx #(.DATA_WIDTH(DW), .PARITY(1), .OVERSAMPLE(OS)) dut1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx1),
    .data_out(dout1), .data_valid(dv1), .parity_err(perr1),
    .frame_err(ferr1), .rx_busy(busy1)
  );

  initial begin
    baud_tick = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      baud_tick = (tick_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
    end
  end

  always @(negedge clk) begin
    if (dv0) begin
      obs0.push_back({dout0, perr0, ferr0});
      vcount0++;
    end
    if (dv1) begin
      obs1.push_back({dout1, perr1, ferr1});
      vcount1++;
    end
  end

  task automatic set_rx(input int dut, input logic v);
    if (dut == 0) rx0 = v;
    else          rx1 = v;
  endtask

  task automatic tick_wait(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (baud_tick) c++;
    end
    #1;
  endtask

  task automatic send_frame(input int dut, input logic [7:0] d, input bit with_par,
                            input logic pbit, input logic stop_bit);
    set_rx(dut, 1'b0);
    tick_wait(OS);
    for (int i = 0; i < DW; i++) begin
      set_rx(dut, d[i]);
      tick_wait(OS);
    end
    if (with_par) begin
      set_rx(dut, pbit);
      tick_wait(OS);
    end
    set_rx(dut, stop_bit);
    tick_wait(OS);
  endtask

  task automatic wait_obs(input int dut, input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (((dut == 0) ? obs0.size() : obs1.size()) >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Even-parity model for dut1: mismatch when data ones plus parity bit is odd.
  function automatic logic even_perr(input logic [7:0] d, input logic pbit);
    return (^d) ^ pbit;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    rx0 = 1'b1;
    rx1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dout0, dv0, perr0, ferr0, busy0} !== 12'h000) begin
      errors++;
      $display("FAIL reset_dut0 got=%h want=000", {dout0, dv0, perr0, ferr0, busy0});
    end
    checks++;
    if ({dout1, dv1, perr1, ferr1, busy1} !== 12'h000) begin
      errors++;
      $display("FAIL reset_dut1 got=%h want=000", {dout1, dv1, perr1, ferr1, busy1});
    end
    rst = 1'b0;
    tick_wait(2 * OS);
  endtask

  task automatic test_8n1();
    int v = vcount0;
    bit ok;
    logic [9:0] got, want;
    exp0.push_back({8'hA5, 1'b0, 1'b0});
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    tick_wait(2 * OS);
    wait_obs(0, 1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL 8n1_timeout got=no data_valid want=1 frame");
      exp0.delete();
    end else begin
      got = obs0.pop_front();
      want = exp0.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL 8n1_frame got=%h want=%h", got, want);
      end
    end
    checks++;
    if (vcount0 - v != 1) begin
      errors++;
      $display("FAIL 8n1_pulses got=%0d want=1", vcount0 - v);
    end
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL 8n1_busy got=%b want=0", busy0);
    end
  endtask

  task automatic test_parity();
    int v = vcount1;
    bit ok;
    logic [9:0] got, want;
    exp1.push_back({8'h07, even_perr(8'h07, 1'b0), 1'b0});
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    tick_wait(2 * OS);
    exp1.push_back({8'h07, even_perr(8'h07, 1'b1), 1'b0});
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    tick_wait(4 * OS);
    wait_obs(1, 2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL parity_timeout got=%0d frames want=2", obs1.size());
      exp1.delete();
      obs1.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        got = obs1.pop_front();
        want = exp1.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL parity_frame%0d got=%h want=%h", i, got, want);
        end
      end
    end
    checks++;
    if (vcount1 - v != 2) begin
      errors++;
      $display("FAIL parity_pulses got=%0d want=2", vcount1 - v);
    end
    checks++;
    if (dout1 !== 8'h07 || perr1 !== 1'b0) begin
      errors++;
      $display("FAIL parity_hold got=%h/%b want=07/0", dout1, perr1);
    end
  endtask

  task automatic test_frame_error();
    int v = vcount0;
    bit ok;
    bit cleared = 1'b0;
    logic [9:0] got, want;
    exp0.push_back({8'h5A, 1'b0, 1'b1});
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0);
    tick_wait(40 * OS);
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL break_busy got=%b want=1", busy0);
    end
    wait_obs(0, 1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL break_timeout got=no data_valid want=1 frame");
      exp0.delete();
    end else begin
      got = obs0.pop_front();
      want = exp0.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL break_frame got=%h want=%h", got, want);
      end
    end
    set_rx(0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (busy0 === 1'b0) begin
        cleared = 1'b1;
        break;
      end
    end
    checks++;
    if (!cleared) begin
      errors++;
      $display("FAIL break_release got=busy %b want=0", busy0);
    end
    tick_wait(4 * OS);
    checks++;
    if (vcount0 - v != 1) begin
      errors++;
      $display("FAIL break_pulses got=%0d want=1", vcount0 - v);
    end
  endtask

  task automatic test_glitch();
    int v = vcount0;
    bit seen = 1'b0;
    bit cleared = 1'b0;
    set_rx(0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) set_rx(0, 1'b1);
      @(posedge clk);
      #1;
      if (busy0 === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL glitch_busy_rise got=0 want=1");
    end
    for (int i = 0; i < OS / 2; i++) begin
      if (busy0 === 1'b0) begin
        cleared = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!cleared) begin
      errors++;
      $display("FAIL glitch_busy_fall got=%b want=0", busy0);
    end
    tick_wait(3 * OS);
    checks++;
    if (vcount0 - v != 0) begin
      errors++;
      $display("FAIL glitch_pulses got=%0d want=0", vcount0 - v);
    end
  endtask

  task automatic test_reset_midframe();
    int v = vcount1;
    bit ok;
    logic [9:0] got, want;
    logic [7:0] d = 8'h3C;
    set_rx(1, 1'b0);
    tick_wait(OS);
    for (int i = 0; i < 3; i++) begin
      set_rx(1, d[i]);
      tick_wait(OS);
    end
    set_rx(1, d[3]);
    tick_wait(OS / 2);
    rst = 1'b1;
    set_rx(1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dout1, dv1, perr1, ferr1, busy1} !== 12'h000) begin
      errors++;
      $display("FAIL midrst_outputs got=%h want=000", {dout1, dv1, perr1, ferr1, busy1});
    end
    checks++;
    if ({dout0, dv0, perr0, ferr0, busy0} !== 12'h000) begin
      errors++;
      $display("FAIL midrst_dut0 got=%h want=000", {dout0, dv0, perr0, ferr0, busy0});
    end
    rst = 1'b0;
    tick_wait(2 * OS);
    checks++;
    if (vcount1 - v != 0) begin
      errors++;
      $display("FAIL midrst_pulses got=%0d want=0", vcount1 - v);
    end
    exp1.push_back({8'hC3, even_perr(8'hC3, 1'b0), 1'b0});
    send_frame(1, 8'hC3, 1'b1, 1'b0, 1'b1);
    tick_wait(2 * OS);
    wait_obs(1, 1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midrst_timeout got=no data_valid want=1 frame");
      exp1.delete();
    end else begin
      got = obs1.pop_front();
      want = exp1.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL midrst_frame got=%h want=%h", got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    int v = vcount1;
    bit ok;
    logic [9:0] got, want;
    exp1.push_back({8'h00, even_perr(8'h00, 1'b0), 1'b0});
    exp1.push_back({8'hFF, even_perr(8'hFF, 1'b0), 1'b0});
    send_frame(1, 8'h00, 1'b1, 1'b0, 1'b1);
    send_frame(1, 8'hFF, 1'b1, 1'b0, 1'b1);
    tick_wait(2 * OS);
    wait_obs(1, 2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_timeout got=%0d frames want=2", obs1.size());
      exp1.delete();
      obs1.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        got = obs1.pop_front();
        want = exp1.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL b2b_frame%0d got=%h want=%h", i, got, want);
        end
      end
    end
    checks++;
    if (vcount1 - v != 2) begin
      errors++;
      $display("FAIL b2b_pulses got=%0d want=2", vcount1 - v);
    end
  endtask

  task automatic test_sparse_tick();
    int v = vcount1;
    bit ok;
    logic [9:0] got, want;
    tick_mode = 1;
    exp1.push_back({8'h96, even_perr(8'h96, 1'b1), 1'b0});
    send_frame(1, 8'h96, 1'b1, 1'b1, 1'b1);
    tick_wait(2 * OS);
    wait_obs(1, 1, ok);
    tick_mode = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sparse_timeout got=no data_valid want=1 frame");
      exp1.delete();
    end else begin
      got = obs1.pop_front();
      want = exp1.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL sparse_frame got=%h want=%h", got, want);
      end
    end
    checks++;
    if (vcount1 - v != 1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL sparse_end got=pulses %0d busy %b want=1/0", vcount1 - v, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_frame_error();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    test_sparse_tick();
    checks++;
    if (obs0.size() != 0 || obs1.size() != 0) begin
      errors++;
      $display("FAIL leftover_frames got=%0d/%0d want=0/0", obs0.size(), obs1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
